mem_stage_be: RTL and testbench

Parametrised MEM stage for the 5-stage RISC-V pipeline, replacing the fixed word-only memory stage. Adds byte/halfword loads and stores (sign/zero extension), misalignment detection, and a configurable wait-state data memory that stalls the pipeline through a counter-driven FSM. Sits between the EX/MEM register and the WB stage and contains the MEM/WB pipeline register.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/dmem_be.sv | 34 +++
 rtl/mem_stage_be.sv | 177 +++++++++++++++++
 tb/tb_mem_stage_be.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-enabled MEM stage.
//   - Funct3 encodings for load/store sizes
//   - mstate_t: wait-state FSM states
//   - msize_t / decode_size(): access-size decode from funct3
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic { IDLE, WAIT } mstate_t;

  typedef enum logic [1:0] { SZ_B, SZ_H, SZ_W } msize_t;

  // Stores only know B/H/W, so BU/HU encodings on a store fall back to a
  // word access, as do all undefined encodings for either direction.
  function automatic msize_t decode_size(input logic [2:0] f3, input logic is_store);
    msize_t sz;
    sz = SZ_W;
    if (is_store) begin
      case (f3)
        F3_B:    sz = SZ_B;
        F3_H:    sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dmem_be.sv
// Byte-enabled data memory: combinational read, synchronous write.
//   clk  : write clock
//   we   : write enable
//   be   : per-byte-lane write enables
//   addr : word index
//   wd   : write data (lane i taken from wd[8i+7:8i])
//   rd   : read data for addr
module dmem_be #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // NOTE: storage has no reset; clearing a RAM array would force it into
  // flops. Contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign rd = mem_q[addr];

endmodule

// File: rtl/mem_stage_be.sv
// MEM stage with byte/halfword access, misalignment detection, a wait-state
// data memory driven by an IDLE/WAIT counter FSM, and the MEM/WB register.
//   Inputs  : EX/MEM register fields (RegWriteM, MemWriteM, MemReadM,
//             ResultSrcM, Funct3M, ALUResultM, WriteDataM, RdM, PCPlus4M)
//   StallM  : combinational freeze request to the hazard unit
//   MisalignM : combinational misaligned-access flag for the op in M
//   *W      : MEM/WB register contents
module mem_stage_be
  import mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int MEM_LATENCY = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PCPlus4M,
  output logic            StallM,
  output logic            MisalignM,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] PCPlus4W
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam bit         HAS_WAIT = (MEM_LATENCY > 0);
  localparam logic [2:0] CNT_LOAD = HAS_WAIT ? 3'(MEM_LATENCY - 1) : 3'd0;

  mstate_t    state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic            regwrite_q;
  logic [1:0]      resultsrc_q;
  logic [XLEN-1:0] aluresult_q, readdata_q, pcplus4_q;
  logic [4:0]      rd_q;

  msize_t      size;
  logic [1:0]  lane;
  logic        is_memop, misaligned, aligned_memop, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wd, rd_word, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        signed_ld;

  assign is_memop = MemReadM | MemWriteM;
  assign size     = decode_size(Funct3M, MemWriteM);
  assign lane     = ALUResultM[1:0];

  always_comb begin
    case (size)
      SZ_H:    misaligned = lane[0];
      SZ_W:    misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign MisalignM     = is_memop & misaligned;
  assign aligned_memop = is_memop & ~misaligned;

  // Gated by reset so the hazard unit never sees a stall while reset is held.
  assign StallM = reset & (((state_q == IDLE) & aligned_memop & HAS_WAIT) |
                           ((state_q == WAIT) & (cnt_q != 3'd0)));

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (aligned_memop && HAS_WAIT) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Store lane steering: replicate the low data so any enabled lane sees it.
  always_comb begin
    mem_be = 4'b1111;
    mem_wd = WriteDataM[31:0];
    case (size)
      SZ_B: begin
        mem_be = 4'b0001 << lane;
        mem_wd = {4{WriteDataM[7:0]}};
      end
      SZ_H: begin
        mem_be = lane[1] ? 4'b1100 : 4'b0011;
        mem_wd = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  // Write only on the completion cycle so a stalled store commits exactly once.
  assign mem_we = reset & MemWriteM & ~misaligned & ~StallM;

  dmem_be #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_dmem (
    .clk  (clk),
    .we   (mem_we),
    .be   (mem_be),
    .addr (ALUResultM[AW+1:2]),
    .wd   (mem_wd),
    .rd   (rd_word)
  );

  assign byte_sel  = rd_word[{lane, 3'b000} +: 8];
  assign half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign signed_ld = ~Funct3M[2];

  always_comb begin
    case (size)
      SZ_B:    load_data = {{24{signed_ld & byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = {{16{signed_ld & half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: a stalled cycle inserts an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || StallM) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
      aluresult_q <= '0;
      readdata_q  <= '0;
      rd_q        <= 5'd0;
      pcplus4_q   <= '0;
    end else begin
      regwrite_q  <= RegWriteM & ~MisalignM;
      resultsrc_q <= ResultSrcM;
      aluresult_q <= ALUResultM;
      readdata_q  <= MemReadM ? load_data : '0;
      rd_q        <= RdM;
      pcplus4_q   <= PCPlus4M;
    end
  end

  assign RegWriteW  = regwrite_q;
  assign ResultSrcW = resultsrc_q;
  assign ALUResultW = aluresult_q;
  assign ReadDataW  = readdata_q;
  assign RdW        = rd_q;
  assign PCPlus4W   = pcplus4_q;

endmodule

// File: tb/tb_mem_stage_be.sv
// Self-checking bench for mem_stage_be. Two instances run side by side:
// index 0 with MEM_LATENCY=0 and index 1 with MEM_LATENCY=3. A byte-array
// reference model predicts stall, misalignment and the W register contents
// every cycle; directed literal checks pin the model to known values.
module tb_mem_stage_be;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        mr;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } op_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } wb_t;

  logic       clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  op_t        op_cur [2] = '{default: '0};
  wb_t        dut_w  [2];
  wb_t        exp_w  [2] = '{default: '0};
  logic [1:0] stall, mis;
  int         age    [2] = '{default: 0};
  logic [7:0] mem_m  [2][256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_stage_be #(
      .XLEN        (32),
      .DEPTH_WORDS (64),
      .MEM_LATENCY (g * 3)
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n[g]),
      .RegWriteM  (op_cur[g].rw),
      .MemWriteM  (op_cur[g].mw),
      .MemReadM   (op_cur[g].mr),
      .ResultSrcM (op_cur[g].rs),
      .Funct3M    (op_cur[g].f3),
      .ALUResultM (op_cur[g].alu),
      .WriteDataM (op_cur[g].wd),
      .RdM        (op_cur[g].rd),
      .PCPlus4M   (op_cur[g].pc4),
      .StallM     (stall[g]),
      .MisalignM  (mis[g]),
      .RegWriteW  (dut_w[g].rw),
      .ResultSrcW (dut_w[g].rs),
      .ALUResultW (dut_w[g].alu),
      .ReadDataW  (dut_w[g].rdata),
      .RdW        (dut_w[g].rd),
      .PCPlus4W   (dut_w[g].pc4)
    );
  end

  // ---------------- reference model ----------------
  function automatic int lat_of(input int g);
    return g * 3;
  endfunction

  function automatic int size_of(input op_t o);
    case (o.f3)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b100:  return o.mw ? 4 : 1;
      3'b101:  return o.mw ? 4 : 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_mis(input op_t o);
    return (o.mr || o.mw) && ((int'(o.alu[1:0]) % size_of(o)) != 0);
  endfunction

  function automatic bit stall_exp(input int g);
    op_t o;
    o = op_cur[g];
    return rst_n[g] && (o.mr || o.mw) && !is_mis(o) && (age[g] < lat_of(g));
  endfunction

  // Byte offset into the 256-byte memory, aligned down to the access size.
  function automatic int base_of(input op_t o);
    int a;
    a = int'(o.alu[7:0]);
    return a - (a % size_of(o));
  endfunction

  function automatic logic [31:0] load_val(input int g, input op_t o);
    int          sz, b;
    logic [31:0] v;
    sz = size_of(o);
    b  = base_of(o);
    v  = 32'd0;
    for (int k = 0; k < sz; k++) v = v | (32'(mem_m[g][b + k]) << (8 * k));
    if (!o.f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!o.f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n[0] or negedge rst_n[1]) begin : model
    op_t o;
    int  b;
    for (int g = 0; g < 2; g++) begin
      if (!rst_n[g]) begin
        age[g]   = 0;
        exp_w[g] = '0;
      end else if (clk) begin
        o = op_cur[g];
        if (stall_exp(g)) begin
          age[g]   = age[g] + 1;
          exp_w[g] = '0;
        end else begin
          age[g]         = 0;
          exp_w[g].rw    = o.rw && !is_mis(o);
          exp_w[g].rs    = o.rs;
          exp_w[g].alu   = o.alu;
          exp_w[g].rdata = o.mr ? load_val(g, o) : 32'd0;
          exp_w[g].rd    = o.rd;
          exp_w[g].pc4   = o.pc4;
          if (o.mw && !is_mis(o)) begin
            b = base_of(o);
            for (int k = 0; k < size_of(o); k++) mem_m[g][b + k] = o.wd[8*k +: 8];
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("stall[%0d]", g), 128'(stall[g]), 128'(stall_exp(g)));
      check($sformatf("misalign[%0d]", g), 128'(mis[g]), 128'(is_mis(op_cur[g])));
      check($sformatf("wb[%0d]", g), 128'(dut_w[g]), 128'(exp_w[g]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it while the model says it is stalled.
  task automatic exec(input int g, input op_t o, output int n, output int ns, output bit sm);
    bit s;
    n  = 0;
    ns = 0;
    sm = 1'b0;
    op_cur[g] = o;
    do begin
      @(negedge clk);
      compare_all();
      s = stall_exp(g);
      if (stall[g]) ns++;
      if (n == 0) sm = mis[g];
      @(posedge clk);
      #1;
      n++;
    end while (s && n < 16);
    if (s) check($sformatf("timeout[%0d]", g), 128'(n), 128'(0));
  endtask

  task automatic run(input int g, input op_t o);
    int n, ns;
    bit sm;
    exec(g, o, n, ns, sm);
    op_cur[g] = '0;
  endtask

  function automatic op_t mk_ld(input logic [2:0] f3, input logic [31:0] a);
    op_t o;
    o     = '0;
    o.rw  = 1'b1;
    o.mr  = 1'b1;
    o.rs  = 2'b01;
    o.f3  = f3;
    o.alu = a;
    o.rd  = 5'($urandom_range(1, 31));
    o.pc4 = $urandom;
    return o;
  endfunction

  function automatic op_t mk_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    op_t o;
    o     = '0;
    o.mw  = 1'b1;
    o.f3  = f3;
    o.alu = a;
    o.wd  = d;
    o.rd  = 5'($urandom_range(0, 31));
    o.pc4 = $urandom;
    return o;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int  n, ns;
    bit  sm;
    op_t o;
    logic [31:0] a;

    tick();
    tick();
    check("reset_w0", 128'(dut_w[0]), 128'(0));
    check("reset_stall1", 128'(stall[1]), 128'(0));
    rst_n = 2'b11;
    tick();

    // Define every memory word so later loads have known contents.
    for (int g = 0; g < 2; g++)
      for (int w = 0; w < 64; w++) run(g, mk_st(3'b010, 32'(w * 4), $urandom));

    // Byte stores and signed/unsigned loads, no wait states.
    run(0, mk_st(3'b010, 32'h10, 32'h1122_3344));
    run(0, mk_st(3'b000, 32'h12, 32'h55AA_11AB));
    run(0, mk_ld(3'b010, 32'h10));
    check("lw_after_sb", 128'(dut_w[0].rdata), 128'(32'h11AB_3344));
    run(0, mk_ld(3'b000, 32'h12));
    check("lb_sext", 128'(dut_w[0].rdata), 128'(32'hFFFF_FFAB));
    run(0, mk_ld(3'b100, 32'h12));
    check("lbu_zext", 128'(dut_w[0].rdata), 128'(32'h0000_00AB));

    // Halfword sign extension.
    run(0, mk_st(3'b001, 32'h22, 32'h7777_8001));
    run(0, mk_ld(3'b001, 32'h22));
    check("lh_sext", 128'(dut_w[0].rdata), 128'(32'hFFFF_8001));
    run(0, mk_ld(3'b101, 32'h22));
    check("lhu_zext", 128'(dut_w[0].rdata), 128'(32'h0000_8001));

    // Misaligned accesses.
    run(0, mk_st(3'b010, 32'h30, 32'hA5A5_A5A5));
    exec(0, mk_ld(3'b010, 32'h13), n, ns, sm);
    check("mis_lw_flag", 128'(sm), 128'(1));
    check("mis_lw_nostall", 128'(ns), 128'(0));
    check("mis_lw_regwrite", 128'(dut_w[0].rw), 128'(0));
    run(0, mk_st(3'b001, 32'h31, 32'h0000_1234));
    run(0, mk_ld(3'b010, 32'h30));
    check("mis_sh_unchanged", 128'(dut_w[0].rdata), 128'(32'hA5A5_A5A5));

    // Address wrap modulo 64 words.
    run(0, mk_st(3'b010, 32'h100, 32'hDEAD_BEEF));
    run(0, mk_ld(3'b010, 32'h000));
    check("addr_wrap", 128'(dut_w[0].rdata), 128'(32'hDEAD_BEEF));

    // Wait states on the latency-3 instance.
    exec(1, mk_st(3'b010, 32'h44, 32'h0BAD_F00D), n, ns, sm);
    check("lat3_sw_cycles", 128'(n), 128'(4));
    check("lat3_sw_stalls", 128'(ns), 128'(3));
    exec(1, mk_ld(3'b010, 32'h44), n, ns, sm);
    check("lat3_lw_cycles", 128'(n), 128'(4));
    check("lat3_lw_stalls", 128'(ns), 128'(3));
    check("lat3_lw_data", 128'(dut_w[1].rdata), 128'(32'h0BAD_F00D));
    check("lat3_lw_regwrite", 128'(dut_w[1].rw), 128'(1));
    exec(1, mk_ld(3'b010, 32'h13), n, ns, sm);
    check("lat3_mis_nostall", 128'(ns), 128'(0));
    op_cur[1] = '0;

    // Reset in the middle of a stalled store.
    run(1, mk_st(3'b010, 32'h48, 32'hCAFE_F00D));
    op_cur[1] = mk_st(3'b010, 32'h48, 32'h1234_5678);
    tick();
    @(negedge clk);
    compare_all();
    #1;
    rst_n[1] = 1'b0;
    #1;
    check("rst_mid_stall", 128'(stall[1]), 128'(0));
    check("rst_mid_w", 128'(dut_w[1]), 128'(0));
    op_cur[1] = '0;
    @(posedge clk);
    #1;
    tick();
    rst_n[1] = 1'b1;
    tick();
    run(1, mk_ld(3'b010, 32'h48));
    check("rst_store_dropped", 128'(dut_w[1].rdata), 128'(32'hCAFE_F00D));

    // Randomised mix of loads, stores, ALU ops and idle slots.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 250; i++) begin
        a = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        if ($urandom_range(0, 3) == 0) a[0] = 1'b0;
        case ($urandom_range(0, 3))
          0: o = mk_ld(3'($urandom_range(0, 7)), a);
          1: o = mk_st(3'($urandom_range(0, 7)), a, $urandom);
          2: begin
            o     = '0;
            o.rw  = 1'($urandom_range(0, 1));
            o.rs  = 2'($urandom_range(0, 3));
            o.f3  = 3'($urandom_range(0, 7));
            o.alu = $urandom;
            o.wd  = $urandom;
            o.rd  = 5'($urandom_range(0, 31));
            o.pc4 = $urandom;
          end
          default: o = '0;
        endcase
        exec(g, o, n, ns, sm);
      end
      op_cur[g] = '0;
      tick();
    end

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
